matmul_accel: RTL and testbench
===============================

Name: matmul_accel

Overview:
- APB-programmed signed integer matrix-multiply engine: C = A×B (+ optional bias C').
- Operands A (N×K) and B (K×M) are held in bus-visible registers. Results go to one of SP_NTARGETS scratchpad matrices, all readable over the bus.
- Sits behind the APB interconnect. The matmul_stimulus/matmul_golden bench pair drives it and checks it over matmul_intf.

Parameters:
- DATA_WIDTH, 8: operand element width, signed.
- BUS_WIDTH, 32: APB data width; also the result element width, signed.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (=4): maximum N, K, M.
- SP_NTARGETS, 4: number of scratchpad result matrices.
- ADDR_WIDTH, 16: APB address width.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- psel_i, in, 1: APB select.
- penable_i, in, 1: APB enable.
- pwrite_i, in, 1: 1 = write.
- paddr_i, in, ADDR_WIDTH: word index (not a byte address).
- pwdata_i, in, BUS_WIDTH: write data.
- pstrb_i, in, BUS_WIDTH/8: byte strobes. Applied to A/B/CONTROL writes; SP writes require all strobes set.
- prdata_o, out, BUS_WIDTH: read data.
- pready_o, out, 1: access-phase ready.
- pslverr_o, out, 1: access error.
- busy_o, out, 1: computation in progress.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all registers, A, B, FLAGS and every SP element are 0. prdata_o, pslverr_o and busy_o are 0. Reset asserted mid-computation aborts it immediately.

Address map (word index):
- 0x000: CONTROL.
- 0x001+i: A row i, i<MAX_DIM. Element k occupies bits [8k+7:8k].
- 0x005+k: B row k, same packing.
- 0x009: FLAGS, read-only. Bit i*MAX_DIM+j is the overflow flag of C[i][j].
- 0x040 + t*MAX_DIM² + i*MAX_DIM + j: SP target t, element C[i][j], full BUS_WIDTH.
- Any other address is unmapped.

CONTROL fields:
- bit0 START: write-1 launches a computation. Self-clearing; always reads 0.
- bit1 MODE_BIAS.
- [3:2] WRITE_TARGET.
- [5:4] READ_TARGET.
- [9:8] N-1, [11:10] K-1, [13:12] M-1.
- All other bits are reserved: read 0, writes ignored.

APB:
- pready_o = 1 in every access phase (zero wait states).
- prdata_o is combinational from paddr_i during the access phase; it is 0 when the access is not a read.
- pslverr_o = 1 in the access phase for any of:
  - an unmapped address;
  - a write to FLAGS;
  - a write to CONTROL, A, B or SP while busy_o = 1.
- Erroring writes have no effect. Reads are always permitted, including while busy.

FSM: IDLE → CALC → IDLE.
- A CONTROL write with START=1 in IDLE latches N, K, M, the targets and the mode.
- FLAGS is cleared to 0 at that point.
- busy_o rises in the following cycle.

CALC:
- Walk i=0..N-1 (outer), then j=0..M-1, then k=0..K-1 (inner).
- One MAC per cycle.
- At k=0 the accumulator is initialised to SP[READ_TARGET][i][j] when MAD_BIAS... precisely: when MODE_BIAS=1, otherwise to 0.
- Each cycle: acc += A[i][k]*B[k][j]. The product is signed, 2·DATA_WIDTH bits, sign-extended.
- On the k=K-1 cycle, SP[WRITE_TARGET][i][j] is written and busy_o falls in the cycle after the final element is written.
- Total busy time is exactly N·M·K cycles.

Arithmetic and boundary cases:
- The accumulator is BUS_WIDTH+1 bits. The stored value is truncated to BUS_WIDTH.
- The overflow flag for an element is set if the true sum falls outside signed BUS_WIDTH range.
- SP elements outside the N×M region are untouched.
- READ_TARGET = WRITE_TARGET is legal: each element is read before it is written.
- A START write while busy gets pslverr_o and is ignored.

Decomposition:
- matmul_pkg holds:
  - DATA_WIDTH, BUS_WIDTH, MAX_DIM, SP_NTARGETS, ADDR_WIDTH;
  - the address-map constants CTRL_ADDR, A_BASE, B_BASE, FLAGS_ADDR, SP_BASE;
  - the CONTROL field bit positions;
  - the FSM state enum.
- Sub-module matmul_mac: signed multiply-accumulate with overflow detection.

Test Plan:
- Reset: read CONTROL, FLAGS and SP 0x040 → all 0; busy_o = 0.
- 2×2×2, no bias: A=[[1,2],[3,4]], B=[[5,6],[7,8]], target 0, START.
  - busy_o is high for exactly 8 cycles.
  - SP0 reads 19, 22, 43, 50.
  - FLAGS = 0.
- Full 4×4×4 with A=-128 everywhere and B=-128 everywhere → every element = 65536 at target 1.
- Bias: preload SP2[0][0] = 0x7FFFFFFF via APB; run 1×1×1 with A=1, B=1, MODE_BIAS=1, READ_TARGET=2, WRITE_TARGET=3.
  - SP3[0][0] = 0x80000000.
  - FLAGS bit0 = 1.
- Bus errors:
  - Read 0x00A → pslverr_o = 1.
  - Write A row 0 while busy → pslverr_o = 1 and A is unchanged.
  - A second START while busy → ignored.
- Reset mid-CALC: assert rst_ni low → busy_o = 0 immediately and the SP reads 0.

Source files
------------

// File: rtl/matmul_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matmul_pkg : shared constants, address map and FSM type for matmul.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package matmul_pkg;
  localparam int DATA_WIDTH  = 8;
  localparam int BUS_WIDTH   = 32;
  localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int SP_NTARGETS = 4;
  localparam int ADDR_WIDTH  = 16;

  localparam int ACC_WIDTH = BUS_WIDTH + 1;
  localparam int IDX_W     = $clog2(MAX_DIM);
  localparam int ELEM_W    = 2 * IDX_W;
  localparam int NELEM     = MAX_DIM * MAX_DIM;
  localparam int TGT_W     = $clog2(SP_NTARGETS);
  localparam int STRB_W    = BUS_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = 16'h0000;
  localparam logic [ADDR_WIDTH-1:0] A_BASE     = 16'h0001;
  localparam logic [ADDR_WIDTH-1:0] B_BASE     = 16'h0005;
  localparam logic [ADDR_WIDTH-1:0] FLAGS_ADDR = 16'h0009;
  localparam logic [ADDR_WIDTH-1:0] SP_BASE    = 16'h0040;
  localparam logic [ADDR_WIDTH-1:0] A_END      = A_BASE + ADDR_WIDTH'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] B_END      = B_BASE + ADDR_WIDTH'(MAX_DIM);
  localparam logic [ADDR_WIDTH-1:0] SP_END     = SP_BASE + ADDR_WIDTH'(SP_NTARGETS * NELEM);

  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_WT_LSB = 2;
  localparam int CTRL_RT_LSB = 4;
  localparam int CTRL_N_LSB  = 8;
  localparam int CTRL_K_LSB  = 10;
  localparam int CTRL_M_LSB  = 12;
  // START is self-clearing, so it is excluded from the stored bits.
  localparam logic [BUS_WIDTH-1:0] CTRL_RW_MASK = 32'h0000_3F3E;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } state_e;

  function automatic logic [BUS_WIDTH-1:0] apply_strb(
    input logic [BUS_WIDTH-1:0] old_v,
    input logic [BUS_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]    strb
  );
    logic [BUS_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction
endpackage
`default_nettype wire

// File: rtl/matmul_accel_mac.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matmul_mac : signed 8x8 multiply added to a 33-bit accumulator, with  |
// | detection of results outside the signed 32-bit range.  Rev 1.0        |
// +-----------------------------------------------------------------------+
module matmul_mac
  import matmul_pkg::*;
(
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o,
  output logic                         ovf_o
);
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod  = a_i * b_i;
  assign acc_o = acc_i + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  // The extra accumulator bit disagreeing with the stored sign bit means the 32-bit value wrapped.
  assign ovf_o = acc_o[ACC_WIDTH-1] ^ acc_o[ACC_WIDTH-2];
endmodule
`default_nettype wire

// File: rtl/matmul_accel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | matmul_accel : APB-programmed signed matrix multiply C = A*B (+bias), |
// | one MAC per cycle into bus-visible scratchpads.  Rev 1.0              |
// +-----------------------------------------------------------------------+
module matmul_accel
  import matmul_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [STRB_W-1:0]     pstrb_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  busy_o
);
  state_e                      state_q, state_d;
  logic [BUS_WIDTH-1:0]        ctrl_q, ctrl_d;
  logic [BUS_WIDTH-1:0]        a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]        a_d [MAX_DIM];
  logic [BUS_WIDTH-1:0]        b_q [MAX_DIM];
  logic [BUS_WIDTH-1:0]        b_d [MAX_DIM];
  logic [BUS_WIDTH-1:0]        sp_q [SP_NTARGETS][NELEM];
  logic [BUS_WIDTH-1:0]        sp_d [SP_NTARGETS][NELEM];
  logic [NELEM-1:0]            flags_q, flags_d;
  logic [IDX_W-1:0]            i_q, i_d, j_q, j_d, k_q, k_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;

  logic access, is_ctrl, is_a, is_b, is_flags, is_sp, mapped, wr_ok;
  logic [IDX_W-1:0]  a_row, b_row;
  logic [TGT_W-1:0]  sp_tgt;
  logic [ELEM_W-1:0] sp_elem;
  logic [BUS_WIDTH-1:0] rdata;

  assign access   = psel_i & penable_i;
  assign is_ctrl  = (paddr_i == CTRL_ADDR);
  assign is_a     = (paddr_i >= A_BASE) && (paddr_i < A_END);
  assign is_b     = (paddr_i >= B_BASE) && (paddr_i < B_END);
  assign is_flags = (paddr_i == FLAGS_ADDR);
  assign is_sp    = (paddr_i >= SP_BASE) && (paddr_i < SP_END);
  assign mapped   = is_ctrl | is_a | is_b | is_flags | is_sp;
  assign a_row    = IDX_W'(paddr_i - A_BASE);
  assign b_row    = IDX_W'(paddr_i - B_BASE);
  assign sp_elem  = ELEM_W'(paddr_i - SP_BASE);
  assign sp_tgt   = TGT_W'((paddr_i - SP_BASE) >> ELEM_W);

  assign pready_o  = 1'b1;
  assign busy_o    = (state_q == S_CALC);
  // Every writable region refuses writes while busy, so writes only land in IDLE.
  assign pslverr_o = access & (~mapped | (pwrite_i & (is_flags | busy_o)));
  assign wr_ok     = access & pwrite_i & ~pslverr_o;

  always_comb begin
    rdata = '0;
    if (is_ctrl)       rdata = ctrl_q;
    else if (is_a)     rdata = a_q[a_row];
    else if (is_b)     rdata = b_q[b_row];
    else if (is_flags) rdata = BUS_WIDTH'(flags_q);
    else if (is_sp)    rdata = sp_q[sp_tgt][sp_elem];
  end
  assign prdata_o = (access & ~pwrite_i) ? rdata : '0;

  logic [IDX_W-1:0]            n_last, k_last, m_last;
  logic [TGT_W-1:0]            wr_tgt, rd_tgt;
  logic                        mode_bias;
  logic [ELEM_W-1:0]           cur_elem;
  logic signed [DATA_WIDTH-1:0] a_el, b_el;
  logic signed [ACC_WIDTH-1:0] bias_v, acc_base, mac_acc;
  logic                        mac_ovf;

  assign n_last    = ctrl_q[CTRL_N_LSB +: IDX_W];
  assign k_last    = ctrl_q[CTRL_K_LSB +: IDX_W];
  assign m_last    = ctrl_q[CTRL_M_LSB +: IDX_W];
  assign wr_tgt    = ctrl_q[CTRL_WT_LSB +: TGT_W];
  assign rd_tgt    = ctrl_q[CTRL_RT_LSB +: TGT_W];
  assign mode_bias = ctrl_q[CTRL_MODE];
  assign cur_elem  = {i_q, j_q};
  assign a_el      = a_q[i_q][{k_q, 3'b000} +: DATA_WIDTH];
  assign b_el      = b_q[k_q][{j_q, 3'b000} +: DATA_WIDTH];
  // Bias is sampled at k=0, before the same element is written back at k=K-1.
  assign bias_v    = mode_bias ? {sp_q[rd_tgt][cur_elem][BUS_WIDTH-1], sp_q[rd_tgt][cur_elem]} : '0;
  assign acc_base  = (k_q == '0) ? bias_v : acc_q;

  matmul_mac u_mac (
    .a_i   (a_el),
    .b_i   (b_el),
    .acc_i (acc_base),
    .acc_o (mac_acc),
    .ovf_o (mac_ovf)
  );

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    sp_d    = sp_q;
    flags_d = flags_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;

    if (wr_ok) begin
      if (is_ctrl) begin
        ctrl_d = apply_strb(ctrl_q, pwdata_i, pstrb_i) & CTRL_RW_MASK;
        if (pstrb_i[0] && pwdata_i[CTRL_START]) begin
          state_d = S_CALC;
          flags_d = '0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      if (is_a) a_d[a_row] = apply_strb(a_q[a_row], pwdata_i, pstrb_i);
      if (is_b) b_d[b_row] = apply_strb(b_q[b_row], pwdata_i, pstrb_i);
      if (is_sp && (&pstrb_i)) sp_d[sp_tgt][sp_elem] = pwdata_i;
    end

    if (state_q == S_CALC) begin
      acc_d = mac_acc;
      if (k_q == k_last) begin
        sp_d[wr_tgt][cur_elem] = mac_acc[BUS_WIDTH-1:0];
        flags_d[cur_elem]      = mac_ovf;
        k_d = '0;
        if (j_q == m_last) begin
          j_d = '0;
          if (i_q == n_last) begin
            i_d     = '0;
            state_d = S_IDLE;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end else begin
        k_d = k_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      sp_q    <= '{default: '0};
      flags_q <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sp_q    <= sp_d;
      flags_q <= flags_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_matmul_accel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_matmul_accel : directed and randomized checks of matmul_accel      |
// | against a behavioural matrix model.  Rev 1.0                          |
// +-----------------------------------------------------------------------+
module tb_matmul_accel;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, busy;

  int total = 0;
  int bad = 0;
  int unsigned bh_cnt = 0;

  logic [31:0] m_ctrl;
  logic [31:0] m_a [4];
  logic [31:0] m_b [4];
  logic [31:0] m_sp [4][16];
  logic [15:0] m_flags;

  matmul_accel dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .psel_i    (psel),
    .penable_i (penable),
    .pwrite_i  (pwrite),
    .paddr_i   (paddr),
    .pwdata_i  (pwdata),
    .pstrb_i   (pstrb),
    .prdata_o  (prdata),
    .pready_o  (pready),
    .pslverr_o (pslverr),
    .busy_o    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (busy) bh_cnt <= bh_cnt + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mk_ctrl(input int n, input int k, input int m,
                                          input int wt, input int rt, input int mode);
    logic [1:0] n2, k2, m2, wt2, rt2;
    n2 = 2'(n - 1); k2 = 2'(k - 1); m2 = 2'(m - 1); wt2 = 2'(wt); rt2 = 2'(rt);
    return {18'b0, m2, k2, n2, 2'b00, rt2, wt2, 1'(mode), 1'b0};
  endfunction

  function automatic void model_reset();
    m_ctrl = '0; m_flags = '0;
    for (int r = 0; r < 4; r++) begin m_a[r] = '0; m_b[r] = '0; end
    for (int t = 0; t < 4; t++) for (int e = 0; e < 16; e++) m_sp[t][e] = '0;
  endfunction

  function automatic void model_wr(input int addr, input logic [31:0] d, input logic [3:0] s);
    if (addr == 0)                      m_ctrl = merge(m_ctrl, d, s) & 32'h0000_3F3E;
    else if (addr >= 1 && addr <= 4)    m_a[addr-1] = merge(m_a[addr-1], d, s);
    else if (addr >= 5 && addr <= 8)    m_b[addr-5] = merge(m_b[addr-5], d, s);
    else if (addr >= 64 && addr < 128 && s == 4'hF) m_sp[(addr-64)/16][(addr-64)%16] = d;
  endfunction

  function automatic logic [31:0] model_rd(input int addr);
    if (addr == 0) return m_ctrl;
    if (addr >= 1 && addr <= 4) return m_a[addr-1];
    if (addr >= 5 && addr <= 8) return m_b[addr-5];
    if (addr == 9) return {16'b0, m_flags};
    if (addr >= 64 && addr < 128) return m_sp[(addr-64)/16][(addr-64)%16];
    return '0;
  endfunction

  // C[i][j] = (bias ? SP[rt][i][j] : 0) + sum_k A[i][k]*B[k][j], stored mod 2^32.
  function automatic void model_calc(input logic [31:0] cw);
    int n, k, m, wt, rt;
    longint s;
    logic [31:0] ar, bc;
    n = int'(cw[9:8]) + 1; k = int'(cw[11:10]) + 1; m = int'(cw[13:12]) + 1;
    wt = int'(cw[3:2]); rt = int'(cw[5:4]);
    m_ctrl  = cw & 32'h0000_3F3E;
    m_flags = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < m; j++) begin
        s = cw[1] ? longint'($signed(m_sp[rt][i*4+j])) : 64'sd0;
        for (int kk = 0; kk < k; kk++) begin
          ar = m_a[i];
          bc = m_b[kk];
          s += longint'($signed(ar[8*kk +: 8])) * longint'($signed(bc[8*j +: 8]));
        end
        m_sp[wt][i*4+j] = s[31:0];
        m_flags[i*4+j]  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    end
  endfunction

  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    #1 err = pslverr;
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a; pstrb = '0;
    @(negedge clk);
    penable = 1'b1;
    #1 begin d = prdata; err = pslverr; end
    @(posedge clk);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [31:0] d, input logic [3:0] s,
                    input logic exp_err, input string tag);
    logic e;
    apb_write(16'(addr), d, s, e);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
    if (!exp_err) model_wr(addr, d, s);
  endtask

  task automatic rd(input int addr, input string tag);
    logic [31:0] d;
    logic e;
    logic mapped;
    mapped = (addr <= 9) || (addr >= 64 && addr < 128);
    apb_read(16'(addr), d, e);
    check({tag, "_err"}, 32'(e), 32'(!mapped));
    check(tag, d, model_rd(addr));
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_calc(input logic [31:0] cw, input string tag);
    logic e;
    int unsigned snap;
    int nmk;
    nmk = (int'(cw[9:8]) + 1) * (int'(cw[11:10]) + 1) * (int'(cw[13:12]) + 1);
    apb_write(16'h0000, cw | 32'h1, 4'hF, e);
    snap = bh_cnt;
    check({tag, "_start_err"}, 32'(e), 32'd0);
    model_calc(cw);
    wait_idle(tag);
    check({tag, "_busy_cycles"}, bh_cnt - snap, 32'(nmk));
  endtask

  initial begin
    logic [31:0] cw, d;
    logic        e;
    int          addr;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_prdata", prdata, 32'd0);
    check("rst_pslverr", 32'(pslverr), 32'd0);
    check("rst_pready", 32'(pready), 32'd1);
    rst_n = 1'b1;
    rd(0, "rst_ctrl");
    rd(9, "rst_flags");
    rd(64, "rst_sp0");

    // 2x2x2 worked example
    wr(1, 32'h0000_0201, 4'hF, 1'b0, "a0");
    wr(2, 32'h0000_0403, 4'hF, 1'b0, "a1");
    wr(5, 32'h0000_0605, 4'hF, 1'b0, "b0");
    wr(6, 32'h0000_0807, 4'hF, 1'b0, "b1");
    run_calc(mk_ctrl(2, 2, 2, 0, 0, 0), "mm222");
    apb_read(16'h0040, d, e); check("mm222_c00", d, 32'd19);
    apb_read(16'h0041, d, e); check("mm222_c01", d, 32'd22);
    apb_read(16'h0044, d, e); check("mm222_c10", d, 32'd43);
    apb_read(16'h0045, d, e); check("mm222_c11", d, 32'd50);
    apb_read(16'h0009, d, e); check("mm222_flags", d, 32'd0);
    apb_read(16'h0000, d, e); check("mm222_ctrl", d, 32'h0000_1500);

    // 4x4x4 of -128 into target 1
    for (int r = 0; r < 4; r++) begin
      wr(1 + r, 32'h8080_8080, 4'hF, 1'b0, "a_m128");
      wr(5 + r, 32'h8080_8080, 4'hF, 1'b0, "b_m128");
    end
    run_calc(mk_ctrl(4, 4, 4, 1, 0, 0), "mm444");
    for (int el = 0; el < 16; el++) begin
      apb_read(16'(80 + el), d, e);
      check("mm444_elem", d, 32'd65536);
    end
    rd(9, "mm444_flags");

    // bias with overflow, read target 2 -> write target 3
    wr(96, 32'h7FFF_FFFF, 4'hF, 1'b0, "sp2_preload");
    wr(1, 32'h0000_0001, 4'hF, 1'b0, "a0_one");
    wr(5, 32'h0000_0001, 4'hF, 1'b0, "b0_one");
    run_calc(mk_ctrl(1, 1, 1, 3, 2, 1), "bias");
    apb_read(16'h0070, d, e); check("bias_sp3", d, 32'h8000_0000);
    apb_read(16'h0009, d, e); check("bias_flags", d, 32'h0000_0001);
    rd(113, "bias_untouched");
    rd(96, "bias_src_kept");

    // bus errors
    rd(10, "unmapped_0a");
    rd(128, "unmapped_80");
    wr(9, 32'hFFFF_FFFF, 4'hF, 1'b1, "flags_write");
    rd(9, "flags_after_write");

    // writes while busy are rejected; reads still work
    cw = mk_ctrl(4, 4, 4, 0, 0, 0);
    apb_write(16'h0000, cw | 32'h1, 4'hF, e);
    addr = int'(bh_cnt);
    check("busy_start_err", 32'(e), 32'd0);
    model_calc(cw);
    check("busy_is_high", 32'(busy), 32'd1);
    wr(1, 32'hDEAD_BEEF, 4'hF, 1'b1, "busy_a_write");
    wr(0, mk_ctrl(1, 1, 1, 3, 3, 1) | 32'h1, 4'hF, 1'b1, "busy_restart");
    wr(64, 32'h1234_5678, 4'hF, 1'b1, "busy_sp_write");
    rd(1, "busy_a_read");
    rd(0, "busy_ctrl_read");
    wait_idle("busy_run");
    check("busy_run_cycles", bh_cnt - 32'(addr), 32'd64);
    rd(1, "busy_a_unchanged");
    rd(0, "busy_ctrl_unchanged");
    for (int el = 0; el < 16; el++) rd(64 + el, "busy_run_elem");

    // randomized runs against the model
    for (int it = 0; it < 8; it++) begin
      for (int r = 0; r < 4; r++) begin
        wr(1 + r, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 1'b0, "rnd_a");
        wr(5 + r, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, 1'b0, "rnd_b");
      end
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 2))
          0:       d = $urandom;
          1:       d = 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
          default: d = 32'h8000_FFFF - 32'($urandom_range(0, 131071));
        endcase
        wr(64 + int'($urandom_range(0, 63)), d,
           ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF, 1'b0, "rnd_sp");
      end
      cw = mk_ctrl($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1));
      run_calc(cw, "rnd");
      for (int el = 0; el < 16; el++) rd(64 + 16 * int'(cw[3:2]) + el, "rnd_elem");
      rd(9, "rnd_flags");
      rd(0, "rnd_ctrl");
    end

    // reset during a computation
    run_calc(mk_ctrl(1, 1, 1, 1, 0, 0), "pre_rst");
    apb_write(16'h0000, mk_ctrl(4, 4, 4, 1, 0, 0) | 32'h1, 4'hF, e);
    repeat (5) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pslverr", 32'(pslverr), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rd(64, "mid_rst_sp0");
    rd(80, "mid_rst_sp1_first");
    rd(95, "mid_rst_sp1_last");
    rd(1, "mid_rst_a0");
    rd(0, "mid_rst_ctrl");
    rd(9, "mid_rst_flags");
    repeat (3) @(negedge clk);
    check("mid_rst_stays_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
